// File: rtl/sound_mixer_pkg.sv
// Shared types, constants and the clamp helper for the N-channel sound mixer.
package sound_mixer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCALE,
      OUTPUT
   } mix_state_t;

   localparam int unsigned FADE_UNITY = 256;
   localparam int unsigned FADE_W     = 9;
   localparam int unsigned FADE_SHIFT = 8;
   localparam int unsigned SAT_W      = 32;

   // Clamp a non-negative accumulator to the largest positive out_w-bit signed value.
   function automatic logic [SAT_W-1:0] sat_u2s(input logic [SAT_W-1:0] acc,
                                                input int unsigned      out_w);
      logic [SAT_W-1:0] max_pos;
      max_pos = (SAT_W'(1) << (out_w - 1)) - SAT_W'(1);
      return (acc > max_pos) ? max_pos : acc;
   endfunction

endpackage

// File: rtl/sound_mixer_nch_if.sv
// Sample-rate handshake and channel bus between the sound generators and the mixer.
interface sound_mixer_nch_if #(
   parameter int unsigned NUM_CH = 6,
   parameter int unsigned IN_W   = 16,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned GAIN_W = 4
);
   logic                       sample_en;
   logic [NUM_CH*IN_W-1:0]     ch_in;
   logic [NUM_CH-1:0]          ch_en;
   logic [NUM_CH*GAIN_W-1:0]   ch_gain;
   logic                       mode;
   logic                       sound_enable;
   logic signed [OUT_W-1:0]    out;
   logic                       out_valid;
   logic                       busy;
   logic                       overrun;

   modport master (
      output sample_en, ch_in, ch_en, ch_gain, mode, sound_enable,
      input  out, out_valid, busy, overrun
   );

   modport slave (
      input  sample_en, ch_in, ch_en, ch_gain, mode, sound_enable,
      output out, out_valid, busy, overrun
   );
endinterface

// File: rtl/mix_fade_ctrl.sv
// Master fade level (0..256) stepped once per mix, and the level multiply.
module mix_fade_ctrl
   import sound_mixer_pkg::*;
#(
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned FADE_STEP = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_en,
   input  logic             sound_enable,
   input  logic [OUT_W-1:0] clamped,
   output logic [OUT_W-1:0] scaled_q
);
   localparam int unsigned PROD_W = OUT_W + FADE_W;

   logic [FADE_W-1:0] level_q, level_d;
   logic [OUT_W-1:0]  scaled_d;
   logic [PROD_W-1:0] prod_c;

   // Step the level toward unity or silence without wrapping, then scale by the new level.
   always_comb begin
      level_d  = level_q;
      scaled_d = scaled_q;
      prod_c   = '0;
      if (step_en) begin
         if (sound_enable) begin
            level_d = (level_q > FADE_W'(FADE_UNITY - FADE_STEP)) ? FADE_W'(FADE_UNITY)
                                                                  : level_q + FADE_W'(FADE_STEP);
         end else begin
            level_d = (level_q < FADE_W'(FADE_STEP)) ? '0 : level_q - FADE_W'(FADE_STEP);
         end
         prod_c   = PROD_W'(clamped) * PROD_W'(level_d);
         scaled_d = OUT_W'(prod_c >> FADE_SHIFT);
      end
   end

   // Level and scaled-sample registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q  <= '0;
         scaled_q <= '0;
      end else begin
         level_q  <= level_d;
         scaled_q <= scaled_d;
      end
   end

endmodule

// File: rtl/sound_mixer_nch.sv
// N-channel gain/bank-masked mixer with saturation and master fade, one channel per clock.
module sound_mixer_nch
   import sound_mixer_pkg::*;
#(
   parameter int unsigned       NUM_CH     = 6,
   parameter int unsigned       IN_W       = 16,
   parameter int unsigned       OUT_W      = 16,
   parameter int unsigned       GAIN_W     = 4,
   parameter int unsigned       GAIN_SHIFT = 3,
   parameter int unsigned       ACC_W      = 24,
   parameter logic [NUM_CH-1:0] BANK0_MASK = 6'b000111,
   parameter logic [NUM_CH-1:0] BANK1_MASK = 6'b111000,
   parameter int unsigned       FADE_STEP  = 16
) (
   input logic              clk,
   input logic              rst,
   sound_mixer_nch_if.slave bus
);
   localparam int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PROD_W = IN_W + GAIN_W;

   mix_state_t         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [IN_W-1:0]    ch_q   [NUM_CH];
   logic [IN_W-1:0]    ch_d   [NUM_CH];
   logic [GAIN_W-1:0]  gain_q [NUM_CH];
   logic [GAIN_W-1:0]  gain_d [NUM_CH];
   logic [NUM_CH-1:0]  mask_q, mask_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;

   logic [PROD_W-1:0]  prod_c;
   logic [ACC_W-1:0]   term_c;
   logic [OUT_W-1:0]   clamped_c;
   logic               scale_c;
   logic [OUT_W-1:0]   scaled_q;

   // Contribution of the current channel: truncating gain scale, zero when masked.
   always_comb begin
      prod_c    = PROD_W'(ch_q[idx_q]) * PROD_W'(gain_q[idx_q]);
      term_c    = mask_q[idx_q] ? ACC_W'(prod_c >> GAIN_SHIFT) : '0;
      clamped_c = OUT_W'(sat_u2s(SAT_W'(acc_q), OUT_W));
      scale_c   = (state_q == SCALE);
   end

   // Mix sequencer: snapshot, accumulate, scale, publish.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      ch_d        = ch_q;
      gain_d      = gain_q;
      mask_d      = mask_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      overrun_d   = overrun_q;

      if (bus.sample_en && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.sample_en) begin
               for (int i = 0; i < NUM_CH; i++) begin
                  ch_d[i]   = bus.ch_in[i*IN_W +: IN_W];
                  gain_d[i] = bus.ch_gain[i*GAIN_W +: GAIN_W];
               end
               mask_d  = bus.ch_en & (bus.mode ? BANK1_MASK : BANK0_MASK);
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + term_c;
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
               state_d = SCALE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         SCALE: begin
            state_d = OUTPUT;
         end
         OUTPUT: begin
            out_d       = scaled_q;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         acc_q       <= '0;
         mask_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i]   <= '0;
            gain_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         mask_q      <= mask_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_q[i]   <= ch_d[i];
            gain_q[i] <= gain_d[i];
         end
      end
   end

   mix_fade_ctrl #(
      .OUT_W     (OUT_W),
      .FADE_STEP (FADE_STEP)
   ) u_fade (
      .clk          (clk),
      .rst          (rst),
      .step_en      (scale_c),
      .sound_enable (bus.sound_enable),
      .clamped      (clamped_c),
      .scaled_q     (scaled_q)
   );

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sound_mixer_nch.sv
// Bench for sound_mixer_nch: behavioural mix model plus per-cycle output compare.
module tb_sound_mixer_nch;

   localparam int NCH = 6;
   localparam int LAT = NCH + 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sound_mixer_nch_if #(.NUM_CH(6), .IN_W(16), .OUT_W(16), .GAIN_W(4)) bus ();

   sound_mixer_nch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   busy_until = 0;
   int   level_m = 0;
   bit   ovr_m   = 0;
   int   last_out = 0;
   exp_t exp_q[$];
   logic [5:0] bank0 = 6'b000111;
   logic [5:0] bank1 = 6'b111000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ch(input int i, input int v, input int g);
      bus.ch_in[i*16 +: 16]  = 16'(v);
      bus.ch_gain[i*4 +: 4]  = 4'(g);
   endtask

   task automatic model_reset();
      level_m    = 0;
      ovr_m      = 0;
      busy_until = 0;
      last_out   = 0;
      exp_q.delete();
   endtask

   // Called in the cycle sample_en is driven: either a new mix or an overrun.
   task automatic model_accept();
      int sum;
      int c;
      int g;
      bit m;
      if (cyc < busy_until) begin
         ovr_m = 1;
         return;
      end
      sum = 0;
      for (int i = 0; i < NCH; i++) begin
         c = int'(bus.ch_in[i*16 +: 16]);
         g = int'(bus.ch_gain[i*4 +: 4]);
         m = bus.ch_en[i] & (bus.mode ? bank1[i] : bank0[i]);
         if (m) sum += (c * g) / 8;
      end
      if (sum > 32767) sum = 32767;
      if (bus.sound_enable) level_m = (level_m + 16 > 256) ? 256 : level_m + 16;
      else                  level_m = (level_m - 16 < 0)   ? 0   : level_m - 16;
      exp_q.push_back('{cyc: cyc + LAT, val: (sum * level_m) / 256});
      busy_until = cyc + LAT;
   endtask

   // Per-cycle compare of every output against the model.
   always @(negedge clk) begin
      bit ev;
      ev = 0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         ev = 1;
         last_out = exp_q[0].val;
         void'(exp_q.pop_front());
      end
      check("out_valid", int'(bus.out_valid), int'(ev));
      check("out", int'(bus.out), last_out);
      check("busy", int'(bus.busy), (cyc < busy_until) ? 1 : 0);
      check("overrun", int'(bus.overrun), int'(ovr_m));
   end

   // One mix; pert 1 flips mode mid-mix, pert 2 scrambles inputs mid-mix; ovr_at pulses sample_en while busy.
   task automatic do_mix(input int pert, input int ovr_at, output int got, output int lat);
      int k;
      k = cyc;
      got = -1;
      lat = -1;
      bus.sample_en = 1'b1;
      model_accept();
      for (int n = 1; n <= 20; n++) begin
         step();
         bus.sample_en = 1'b0;
         if (n == ovr_at) begin
            bus.sample_en = 1'b1;
            model_accept();
         end
         if (pert == 1 && n == 2) bus.mode = ~bus.mode;
         if (pert == 2 && n <= 8) begin
            bus.ch_in   = {3{32'($urandom)}};
            bus.ch_gain = 24'($urandom);
            bus.ch_en   = 6'($urandom);
            bus.mode    = 1'($urandom);
         end
         if (bus.out_valid) begin
            got = int'(bus.out);
            lat = cyc - k;
            break;
         end
      end
      if (lat < 0) check("mix_timeout", lat, LAT);
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NCH; i++) begin
         set_ch(i, ($urandom_range(0, 3) == 0) ? 16'hFFFF : int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 15)));
      end
      bus.ch_en = 6'($urandom);
      bus.mode  = 1'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      int lat;
      int k;
      rst              = 1'b1;
      bus.sample_en    = 1'b0;
      bus.ch_in        = '0;
      bus.ch_gain      = '0;
      bus.ch_en        = 6'h3F;
      bus.mode         = 1'b0;
      bus.sound_enable = 1'b1;
      repeat (3) step();
      check("reset_out", int'(bus.out), 0);
      check("reset_valid", int'(bus.out_valid), 0);
      check("reset_busy", int'(bus.busy), 0);
      check("reset_overrun", int'(bus.overrun), 0);
      rst = 1'b0;
      step();

      // Fade in from reset, then out, then back to unity.
      set_ch(0, 16'h4000, 8);
      for (int n = 1; n <= 16; n++) begin
         do_mix(0, 0, got, lat);
         check("fade_up", got, 1024 * n);
         if (n == 1) check("latency", lat, 9);
      end
      bus.sound_enable = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         do_mix(0, 0, got, lat);
         check("fade_down", got, 16384 - 1024 * n);
      end
      bus.sound_enable = 1'b1;
      for (int n = 1; n <= 16; n++) do_mix(0, 0, got, lat);

      do_mix(0, 0, got, lat);
      check("unity_single", got, 16384);

      for (int i = 0; i < 3; i++)   set_ch(i, 16'h4000, 1);
      for (int i = 3; i < NCH; i++) set_ch(i, 16'hFFFF, 1);
      do_mix(0, 0, got, lat);
      check("attenuation", got, 6144);

      bus.mode = 1'b1;
      for (int i = 3; i < NCH; i++) set_ch(i, 16'h2000, 8);
      do_mix(0, 0, got, lat);
      check("bank1", got, 24576);
      do_mix(1, 0, got, lat);
      check("bank1_mode_flip", got, 24576);
      do_mix(0, 0, got, lat);
      check("bank0_after_flip", got, 6144);

      for (int i = 0; i < NCH; i++) set_ch(i, 16'hFFFF, 15);
      do_mix(0, 0, got, lat);
      check("saturate", got, 32767);
      bus.ch_en = 6'h00;
      do_mix(0, 0, got, lat);
      check("all_disabled", got, 0);
      bus.ch_en = 6'h3F;

      do_mix(0, 1, got, lat);
      check("overrun_mix", got, 32767);
      check("overrun_flag", int'(bus.overrun), 1);

      // Reset during the third accumulate cycle.
      k = cyc;
      bus.sample_en = 1'b1;
      model_accept();
      step();
      bus.sample_en = 1'b0;
      while (cyc < k + 3) step();
      rst = 1'b1;
      model_reset();
      #1;
      check("midrst_out", int'(bus.out), 0);
      check("midrst_valid", int'(bus.out_valid), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_overrun", int'(bus.overrun), 0);
      step();
      rst = 1'b0;
      repeat (12) step();
      for (int i = 0; i < NCH; i++) set_ch(i, 0, 0);
      set_ch(0, 16'h4000, 8);
      do_mix(0, 0, got, lat);
      check("after_reset_mix", got, 1024);

      // Randomized mixes with gaps, mid-mix input churn and stray strobes.
      for (int t = 0; t < 60; t++) begin
         rand_inputs();
         bus.sound_enable = ($urandom_range(0, 3) != 0);
         repeat ($urandom_range(0, 3)) step();
         do_mix(int'($urandom_range(0, 2)),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 8)) : 0, got, lat);
      end
      repeat (4) step();
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
